// File: rtl/elastic_buffer_pkg.sv
// elastic_buffer shared types and helpers.
// Event encoding, stats width, ring pointer increment.
package elastic_buffer_pkg;

  typedef enum logic [2:0] {
    EV_IDLE,
    EV_LOAD,
    EV_FLOW,
    EV_UNLOAD,
    EV_DUMP
  } buf_event_t;

  localparam int DropCountWidth = 16;

  function automatic int unsigned ptr_inc(
    input int unsigned ptr,
    input int unsigned depth
  );
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/elastic_reg.sv
// Register slice with enable and async active-low reset.
// Reset value is a parameter so one cell serves every state bit.
module elastic_reg #(
  parameter int             W   = 1,
  parameter logic [W-1:0]   RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold state; load d when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST;
    else if (en) q <= d;
  end

endmodule

// File: rtl/elastic_buffer.sv
// DEPTH-entry ring buffer, registered ready_in/valid_out.
// ELASTIC_BUFFER_STATS_EN adds the drop_count port.
module elastic_buffer
  import elastic_buffer_pkg::*;
#(
  parameter int DATA_WIDTH           = 8,
  parameter int DEPTH                = 4,
  parameter int CIRCULAR_BUFFER_MODE = 0,
  parameter int ALMOST_FULL_LEVEL    = DEPTH - 1,
  localparam int CntW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [CntW-1:0]       occupancy,
  output logic                  almost_full
`ifdef ELASTIC_BUFFER_STATS_EN
  ,
  output logic [DropCountWidth-1:0] drop_count
`endif
);

  localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfLvl  = CntW'(ALMOST_FULL_LEVEL);
  localparam bit  Circ   = (CIRCULAR_BUFFER_MODE != 0);
  localparam bit  AfRst  = (ALMOST_FULL_LEVEL == 0);

  if (DEPTH < 2 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_cfg
    $error("elastic_buffer: need DEPTH>=2, ALMOST_FULL_LEVEL<=DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [CntW-1:0] cnt_nxt;
  logic            insert, remove, full;
  logic            c_dump, c_flow, c_load, c_unload;
  logic            rdy_nxt, vld_nxt, af_nxt;
  buf_event_t      ev;

  assign insert = valid_in & ready_in;
  assign remove = valid_out & ready_out;
  assign full   = (occupancy == DepthC);

  assign c_dump   = insert & ~remove & full & Circ;
  assign c_flow   = insert & remove;
  assign c_load   = insert & ~remove & ~c_dump;
  assign c_unload = ~insert & remove;

  // Classify this cycle's handshakes into one event.
  always_comb begin
    ev = EV_IDLE;
    unique case (1'b1)
      c_dump:   ev = EV_DUMP;
      c_flow:   ev = EV_FLOW;
      c_load:   ev = EV_LOAD;
      c_unload: ev = EV_UNLOAD;
      default:  ev = EV_IDLE;
    endcase
  end

  // Pointer and count updates for each event.
  always_comb begin
    rd_nxt  = rd_ptr;
    wr_nxt  = wr_ptr;
    cnt_nxt = occupancy;
    unique case (ev)
      EV_LOAD: begin
        wr_nxt  = PtrW'(ptr_inc(32'(wr_ptr), DEPTH));
        cnt_nxt = occupancy + CntW'(1);
      end
      EV_UNLOAD: begin
        rd_nxt  = PtrW'(ptr_inc(32'(rd_ptr), DEPTH));
        cnt_nxt = occupancy - CntW'(1);
      end
      EV_FLOW, EV_DUMP: begin
        rd_nxt = PtrW'(ptr_inc(32'(rd_ptr), DEPTH));
        wr_nxt = PtrW'(ptr_inc(32'(wr_ptr), DEPTH));
      end
      default: ;
    endcase
  end

  assign rdy_nxt = (cnt_nxt < DepthC) || Circ;
  assign vld_nxt = (cnt_nxt != '0);
  assign af_nxt  = (cnt_nxt >= AfLvl);

  elastic_reg #(.W(PtrW)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .en(1'b1),
    .d(rd_nxt), .q(rd_ptr)
  );

  elastic_reg #(.W(PtrW)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .en(1'b1),
    .d(wr_nxt), .q(wr_ptr)
  );

  elastic_reg #(.W(CntW)) u_count (
    .clk(clk), .rst_n(rst_n), .en(1'b1),
    .d(cnt_nxt), .q(occupancy)
  );

  elastic_reg #(.W(1), .RST(1'b1)) u_ready (
    .clk(clk), .rst_n(rst_n), .en(1'b1),
    .d(rdy_nxt), .q(ready_in)
  );

  elastic_reg #(.W(1)) u_valid (
    .clk(clk), .rst_n(rst_n), .en(1'b1),
    .d(vld_nxt), .q(valid_out)
  );

  elastic_reg #(.W(1), .RST(AfRst)) u_afull (
    .clk(clk), .rst_n(rst_n), .en(1'b1),
    .d(af_nxt), .q(almost_full)
  );

  // Storage flops; written at wr_ptr on every accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (insert) begin
      mem[wr_ptr] <= data_in;
    end
  end

  assign data_out = mem[rd_ptr];

`ifdef ELASTIC_BUFFER_STATS_EN
  // Saturating count of entries overwritten by dumps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_count <= '0;
    else if (ev == EV_DUMP && drop_count != '1)
      drop_count <= drop_count + DropCountWidth'(1);
  end
`endif

endmodule

// File: tb/tb_elastic_buffer.sv
// Bench for elastic_buffer: normal and circular instances.
// Scoreboards pushed on insert, popped on remove.
module tb_elastic_buffer;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0]    din = '0, dout;
  logic          vin = 1'b0, rin, vout, rout = 1'b0;
  logic [CW-1:0] occ;
  logic          af;

  logic [7:0]    cdin = '0, cdout;
  logic          cvin = 1'b0, crin, cvout, crout = 1'b0;
  logic [CW-1:0] cocc;
  logic          caf;
`ifdef ELASTIC_BUFFER_STATS_EN
  logic [15:0]   cdrop;
`endif

  logic [7:0] sbq[$];
  logic [7:0] cq[$];
  int vectors = 0;
  int miscompares = 0;
  int pops = 0;

  always #5 clk = ~clk;

  elastic_buffer #(.DATA_WIDTH(8), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .data_in(din), .valid_in(vin), .ready_in(rin),
    .data_out(dout), .valid_out(vout), .ready_out(rout),
    .occupancy(occ), .almost_full(af)
`ifdef ELASTIC_BUFFER_STATS_EN
    , .drop_count()
`endif
  );

  elastic_buffer #(
    .DATA_WIDTH(8), .DEPTH(DEPTH), .CIRCULAR_BUFFER_MODE(1)
  ) u_circ (
    .clk(clk), .rst_n(rst_n),
    .data_in(cdin), .valid_in(cvin), .ready_in(crin),
    .data_out(cdout), .valid_out(cvout), .ready_out(crout),
    .occupancy(cocc), .almost_full(caf)
`ifdef ELASTIC_BUFFER_STATS_EN
    , .drop_count(cdrop)
`endif
  );

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // One clock: record handshakes, advance to next negedge.
  task automatic step();
    logic [7:0] e;
    if (vout && rout) begin
      vectors++; pops++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL pop_empty got %h, queue empty", dout);
      end else begin
        e = sbq.pop_front();
        if (dout !== e) begin
          miscompares++;
          $display("FAIL data_out got %h want %h", dout, e);
        end
      end
    end
    if (vin && rin) sbq.push_back(din);
    if (cvout && crout) begin
      vectors++;
      if (cq.size() == 0) begin
        miscompares++;
        $display("FAIL c_pop_empty got %h", cdout);
      end else begin
        e = cq.pop_front();
        if (cdout !== e) begin
          miscompares++;
          $display("FAIL c_data_out got %h want %h", cdout, e);
        end
      end
    end else if (cvin && crin && cq.size() == DEPTH) begin
      void'(cq.pop_front());
    end
    if (cvin && crin) cq.push_back(cdin);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vin = 0; rout = 0; cvin = 0; crout = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sbq.delete();
    cq.delete();
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    vin = 0; rout = 1;
    while (vout && n < 20) begin step(); n++; end
    vectors++;
    if (vout !== 1'b0 || occ !== 0 || sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain vout=%b occ=%0d q=%0d want 0 0 0",
               vout, occ, sbq.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rin, vout, af, occ, dout} !== {3'b100, CW'(0), 8'h00}) begin
      miscompares++;
      $display("FAIL reset rin=%b vout=%b af=%b occ=%0d dout=%h",
               rin, vout, af, occ, dout);
    end
    vectors++;
    if ({crin, cvout, cocc} !== {2'b10, CW'(0)}) begin
      miscompares++;
      $display("FAIL c_reset crin=%b cvout=%b cocc=%0d",
               crin, cvout, cocc);
    end
`ifdef ELASTIC_BUFFER_STATS_EN
    vectors++;
    if (cdrop !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_drop got %0d want 0", cdrop);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    rout = 1; vin = 1; din = 8'hA5;
    step();
    vin = 0;
    vectors++;
    if ({vout, rin, dout, occ} !== {2'b11, 8'hA5, CW'(1)}) begin
      miscompares++;
      $display("FAIL single vout=%b rin=%b dout=%h occ=%0d want 1 1 a5 1",
               vout, rin, dout, occ);
    end
    step();
    vectors++;
    if ({vout, rin, occ} !== {2'b01, CW'(0)}) begin
      miscompares++;
      $display("FAIL single_after vout=%b rin=%b occ=%0d want 0 1 0",
               vout, rin, occ);
    end
  endtask

  task automatic test_fill();
    logic [7:0] w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    rout = 0;
    for (int k = 0; k < 4; k++) begin
      vin = 1; din = w[k];
      step();
      vectors++;
      if (occ !== CW'(k + 1) || af !== (k >= 2) || rin !== (k < 3)) begin
        miscompares++;
        $display("FAIL fill_%0d occ=%0d af=%b rin=%b", k, occ, af, rin);
      end
    end
    din = 8'h55;
    step();
    vectors++;
    if (occ !== CW'(4) || rin !== 1'b0) begin
      miscompares++;
      $display("FAIL blocked occ=%0d rin=%b want 4 0", occ, rin);
    end
    vin = 0; rout = 1;
    step();
    vectors++;
    if (occ !== CW'(3) || rin !== 1'b1) begin
      miscompares++;
      $display("FAIL first_remove occ=%0d rin=%b want 3 1", occ, rin);
    end
    drain();
  endtask

  task automatic test_full_simul();
    rout = 0;
    for (int k = 0; k < 4; k++) begin
      vin = 1; din = 8'h61 + 8'(k);
      step();
    end
    rout = 1; vin = 1; din = 8'h99;
    step();
    vectors++;
    if (occ !== CW'(3) || rin !== 1'b1) begin
      miscompares++;
      $display("FAIL full_simul occ=%0d rin=%b want 3 1", occ, rin);
    end
    step();
    vectors++;
    if (occ !== CW'(3) || sbq.size() != 3) begin
      miscompares++;
      $display("FAIL accept_after occ=%0d q=%0d want 3 3",
               occ, sbq.size());
    end
    drain();
  endtask

  task automatic test_wrap();
    int sent = 0;
    int start = pops;
    int n = 0;
    din = 8'h80;
    vin = ($urandom_range(0, 3) != 0);
    while ((sent < 40 || vout) && n < 2000) begin
      rout = ($urandom_range(0, 3) != 0);
      if (vin && rin) sent++;
      step();
      if (!(vin && !rin)) begin
        if (vin) din = din + 8'd1;
        vin = (sent < 40) && ($urandom_range(0, 3) != 0);
      end
      n++;
    end
    vin = 0;
    vectors++;
    if (pops - start != 40 || sbq.size() != 0) begin
      miscompares++;
      $display("FAIL wrap popped %0d want 40, left %0d",
               pops - start, sbq.size());
    end
  endtask

  task automatic test_circular();
    crout = 0;
    for (int k = 1; k <= 6; k++) begin
      cvin = 1; cdin = 8'(k);
      step();
    end
    cvin = 0;
    vectors++;
    if ({cdout, cocc, cvout, crin} !== {8'h03, CW'(4), 2'b11}) begin
      miscompares++;
      $display("FAIL dump dout=%h occ=%0d v=%b r=%b want 03 4 1 1",
               cdout, cocc, cvout, crin);
    end
`ifdef ELASTIC_BUFFER_STATS_EN
    vectors++;
    if (cdrop !== 16'd2) begin
      miscompares++;
      $display("FAIL drop_count got %0d want 2", cdrop);
    end
`endif
    crout = 1; cvin = 1; cdin = 8'h07;
    step();
    cvin = 0;
    vectors++;
    if (cocc !== CW'(4) || cdout !== 8'h04) begin
      miscompares++;
      $display("FAIL pass occ=%0d dout=%h want 4 04", cocc, cdout);
    end
`ifdef ELASTIC_BUFFER_STATS_EN
    vectors++;
    if (cdrop !== 16'd2) begin
      miscompares++;
      $display("FAIL pass_drop got %0d want 2", cdrop);
    end
`endif
    for (int k = 0; k < 4; k++) step();
    crout = 0;
    vectors++;
    if (cvout !== 1'b0 || cocc !== CW'(0) || cq.size() != 0) begin
      miscompares++;
      $display("FAIL c_drain v=%b occ=%0d q=%0d want 0 0 0",
               cvout, cocc, cq.size());
    end
  endtask

  task automatic test_async_reset();
    rout = 0;
    for (int k = 0; k < 3; k++) begin
      vin = 1; din = 8'hB0 + 8'(k);
      step();
    end
    vin = 0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({vout, rin, af, occ} !== {3'b010, CW'(0)}) begin
      miscompares++;
      $display("FAIL async_reset v=%b r=%b af=%b occ=%0d want 0 1 0 0",
               vout, rin, af, occ);
    end
    sbq.delete();
    cq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rout = 1; vin = 1; din = 8'hC3;
    step();
    vin = 0;
    vectors++;
    if (vout !== 1'b1 || dout !== 8'hC3) begin
      miscompares++;
      $display("FAIL post_reset v=%b dout=%h want 1 c3", vout, dout);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_simul();
    test_wrap();
    do_reset();
    test_circular();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
